// File: rtl/reel_controller.sv
// Turn sequencer for the one-arm-bandit: spins three BCD reels, stops them in order on
// button press or timeout, hands the triple to Score and waits for its verdict.
module reel_controller #(
    parameter int SPIN_DIV  = 4,
    parameter int AUTO_STOP = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_p,
    input  logic       stop_p,
    input  logic       pass_p,
    input  logic       lose_p,
    output logic       turn_p,
    output logic       ref_sign,
    output logic [1:0] refresh,
    output logic [3:0] number1,
    output logic [3:0] number2,
    output logic [3:0] number3,
    output logic       score_sign,
    output logic       busy
);

    localparam int DW = $clog2(SPIN_DIV);
    localparam int TW = $clog2(AUTO_STOP);
    localparam logic [DW-1:0] DIV_LAST = DW'(SPIN_DIV - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(AUTO_STOP - 1);
    localparam logic [2:0][3:0] STEP = {4'd7, 4'd3, 4'd1};

    typedef enum logic [2:0] {S_IDLE, S_SPIN, S_SCORE, S_WAIT, S_OVER} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [2:0]      run_q, run_d;
    logic [1:0]      refresh_q, refresh_d;
    logic [2:0][3:0] num_q, num_d;
    logic            turn_q, turn_d;
    logic            ref_q, ref_d;
    logic            score_q, score_d;
    logic            busy_q, busy_d;
    logic            tick, stop_now;

    function automatic logic [3:0] bcd_add(input logic [3:0] v, input logic [3:0] k);
        logic [4:0] s;
        s = {1'b0, v} + {1'b0, k};
        if (s >= 5'd10) s = s - 5'd10;
        return s[3:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        tmr_d     = tmr_q;
        run_d     = run_q;
        refresh_d = refresh_q;
        num_d     = num_q;
        turn_d    = 1'b0;
        ref_d     = 1'b0;
        score_d   = 1'b0;
        tick      = 1'b0;
        stop_now  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    state_d   = S_SPIN;
                    turn_d    = 1'b1;
                    refresh_d = 2'd0;
                    div_d     = '0;
                    tmr_d     = '0;
                    run_d     = 3'b111;
                end
            end
            S_SPIN: begin
                tick     = (div_q == DIV_LAST);
                div_d    = tick ? '0 : div_q + DW'(1);
                stop_now = stop_p || (tmr_q == TMR_LAST);
                if (stop_now) begin
                    // Clearing the lowest set bit freezes the lowest-index spinning reel.
                    run_d     = run_q & (run_q - 3'd1);
                    tmr_d     = '0;
                    ref_d     = 1'b1;
                    refresh_d = (refresh_q == 2'd3) ? 2'd3 : refresh_q + 2'd1;
                    if (run_d == 3'b000) state_d = S_SCORE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
                // Stepping uses run_d so a reel stopped on a tick keeps its pre-step value.
                for (int i = 0; i < 3; i++) begin
                    if (tick && run_d[i]) num_d[i] = bcd_add(num_q[i], STEP[i]);
                end
            end
            S_SCORE: begin
                score_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lose_p)      state_d = S_OVER;
                else if (pass_p) state_d = S_IDLE;
            end
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_SPIN) || (state_d == S_SCORE) || (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            tmr_q     <= '0;
            run_q     <= 3'b000;
            refresh_q <= 2'd0;
            num_q     <= '0;
            turn_q    <= 1'b0;
            ref_q     <= 1'b0;
            score_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            tmr_q     <= tmr_d;
            run_q     <= run_d;
            refresh_q <= refresh_d;
            num_q     <= num_d;
            turn_q    <= turn_d;
            ref_q     <= ref_d;
            score_q   <= score_d;
            busy_q    <= busy_d;
        end
    end

    assign turn_p     = turn_q;
    assign ref_sign   = ref_q;
    assign refresh    = refresh_q;
    assign number1    = num_q[0];
    assign number2    = num_q[1];
    assign number3    = num_q[2];
    assign score_sign = score_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_reel_controller.sv
// Self-checking bench for reel_controller: directed scenarios plus random play, all
// compared every cycle against an event-counting reference model.
module tb_reel_controller;

    localparam int SPIN_DIV  = 4;
    localparam int AUTO_STOP = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_p = 1'b0, stop_p = 1'b0, pass_p = 1'b0, lose_p = 1'b0;
    logic       turn_p, ref_sign, score_sign, busy;
    logic [1:0] refresh;
    logic [3:0] number1, number2, number3;

    reel_controller #(.SPIN_DIV(SPIN_DIV), .AUTO_STOP(AUTO_STOP)) dut (
        .clk(clk), .rst_n(rst_n), .start_p(start_p), .stop_p(stop_p),
        .pass_p(pass_p), .lose_p(lose_p), .turn_p(turn_p), .ref_sign(ref_sign),
        .refresh(refresh), .number1(number1), .number2(number2), .number3(number3),
        .score_sign(score_sign), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 idle, 1 spin, 2 score, 3 wait, 4 over.
    int mphase, t_turn, t_stop, nstop;
    int reel[3];
    int inc[3] = '{1, 3, 7};
    int e_turn, e_ref, e_refresh, e_score, e_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mphase = 0; t_turn = 0; t_stop = 0; nstop = 0;
        for (int i = 0; i < 3; i++) reel[i] = 0;
        e_turn = 0; e_ref = 0; e_refresh = 0; e_score = 0; e_busy = 0;
    endtask

    task automatic model_step(input logic s, input logic p, input logic pa, input logic lo);
        e_turn = 0; e_ref = 0; e_score = 0;
        case (mphase)
            0: if (s) begin
                mphase = 1; e_turn = 1; e_refresh = 0; t_turn = 0; t_stop = 0; nstop = 0;
            end
            1: begin
                t_turn++;
                t_stop++;
                if (p || t_stop == AUTO_STOP) begin
                    nstop++;
                    e_ref = 1;
                    e_refresh = nstop;
                    t_stop = 0;
                end
                if (t_turn % SPIN_DIV == 0)
                    for (int i = nstop; i < 3; i++) reel[i] = (reel[i] + inc[i]) % 10;
                if (nstop == 3) mphase = 2;
            end
            2: begin e_score = 1; mphase = 3; end
            3: if (lo) mphase = 4; else if (pa) mphase = 0;
            default: ;
        endcase
        e_busy = (mphase >= 1 && mphase <= 3) ? 1 : 0;
    endtask

    task automatic compare_all();
        chk("turn_p", turn_p, e_turn);
        chk("ref_sign", ref_sign, e_ref);
        chk("refresh", refresh, e_refresh);
        chk("score_sign", score_sign, e_score);
        chk("busy", busy, e_busy);
        chk("number1", number1, reel[0]);
        chk("number2", number2, reel[1]);
        chk("number3", number3, reel[2]);
    endtask

    task automatic cyc(input logic s, input logic p, input logic pa, input logic lo);
        start_p = s; stop_p = p; pass_p = pa; lose_p = lo;
        @(posedge clk);
        model_step(s, p, pa, lo);
        #1;
        compare_all();
        start_p = 1'b0; stop_p = 1'b0; pass_p = 1'b0; lose_p = 1'b0;
    endtask

    // Called just after a sampling point; drops reset well clear of any clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int stop_cyc[$];
        bit found;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Ignored inputs in IDLE, then a turn with three manual stops.
        cyc(0, 1, 1, 1);
        cyc(1, 0, 0, 0);
        chk("turn_first", turn_p, 1);
        cyc(1, 0, 0, 0);
        chk("start_in_spin", turn_p, 0);
        repeat (11) cyc(0, 0, 0, 0);
        chk("tick3_n1", number1, 3);
        chk("tick3_n2", number2, 9);
        chk("tick3_n3", number3, 1);
        for (int k = 0; k < 3; k++) begin
            repeat (9) cyc(0, 0, 1, 0);
            cyc(0, 1, 0, 0);
            chk("stop_ref", ref_sign, 1);
            chk("stop_refresh", refresh, k + 1);
        end
        cyc(1, 1, 0, 0);
        chk("score_after_ref", score_sign, 1);
        repeat (5) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        chk("pass_busy", busy, 0);

        // Turn driven only by auto-stop.
        cyc(1, 0, 0, 0);
        for (int j = 1; j <= 250; j++) begin
            cyc(0, 0, 0, 0);
            if (ref_sign) stop_cyc.push_back(j);
            if (score_sign) break;
        end
        chk("auto_count", stop_cyc.size(), 3);
        for (int k = 0; k < 3 && k < stop_cyc.size(); k++)
            chk("auto_time", stop_cyc[k], 64 * (k + 1));
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        chk("both_verdict_busy", busy, 0);
        cyc(1, 0, 0, 0);
        chk("over_no_turn", turn_p, 0);
        repeat (3) cyc(1, 1, 1, 0);
        do_reset();

        // Stop coinciding with a step tick while reel 2 reads 8.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        found = 0;
        for (int j = 0; j < 200 && !found; j++) begin
            if (mphase == 1 && nstop == 1 && reel[1] == 8 && (t_turn + 1) % SPIN_DIV == 0
                && t_stop + 1 < AUTO_STOP) begin
                cyc(0, 1, 0, 0);
                chk("coincide_n2", number2, 8);
                found = 1;
            end else begin
                cyc(0, 0, 0, 0);
            end
        end
        if (!found) chk("coincide_found", 0, 1);
        repeat (8) cyc(0, 0, 0, 0);
        chk("coincide_hold_n2", number2, 8);
        do_reset();

        // Asynchronous reset in the middle of a spin.
        cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        chk("refresh_mid", refresh, 1);
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_refresh", refresh, 0);

        // Random play.
        for (int c = 0; c < 4000; c++) begin
            if ((mphase == 4 && $urandom_range(0, 15) == 0) || $urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reel_controller.md
# reel_controller

Turn sequencer for the one-arm-bandit game: it produces the reel values and control strobes that the `Score` block consumes, and it reacts to `Score`'s `pass_p`/`lose_p` verdicts. On a lever pulse it spins three decimal reels, stops them one at a time on button presses or on timeout, then hands the frozen triple to `Score` and waits for the verdict. It sits between the debounced player inputs and `Score`.

## Interface
- `SPIN_DIV`, 4: clock cycles per reel step while spinning (≥2).
- `AUTO_STOP`, 64: cycles without `stop_p` before the next reel stops automatically (≥2).

- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start_p` in 1: lever pulse, one cycle.
- `stop_p` in 1: stop-button pulse, one cycle.
- `pass_p` in 1: verdict from `Score`, turn passed.
- `lose_p` in 1: verdict from `Score`, game lost.
- `turn_p` out 1: one-cycle pulse, new turn started.
- `ref_sign` out 1: one-cycle pulse, a reel just stopped.
- `refresh` out 2: number of reels stopped in the current turn (0–3).
- `number1`, `number2`, `number3` out 4 each: reel values, BCD 0–9.
- `score_sign` out 1: one-cycle pulse, triple is final and ready to score.
- `busy` out 1: high in every state except IDLE and OVER.

## Operation
- FSM states: IDLE, SPIN, SCORE, WAIT, OVER. All outputs are registered.
- Reset values: state IDLE; all numbers 0; `refresh` 0; all pulse outputs 0; `busy` 0; counters 0.
- IDLE + `start_p`: go to SPIN, pulse `turn_p`, set `refresh` to 0, clear the divider and auto-stop timer. Reels resume from their previous values.
- SPIN stepping:
  - The divider counts 0..SPIN_DIV-1. On the terminal count, every still-spinning reel steps.
  - Step sizes, all mod 10: reel 1 +1, reel 2 +3, reel 3 +7.
- SPIN stopping:
  - `stop_p`, or the auto-stop timer reaching AUTO_STOP-1, freezes the lowest-index spinning reel.
  - On a stop: increment `refresh`, pulse `ref_sign`, clear the timer.
  - The third stop moves the FSM to SCORE.
- SCORE: pulse `score_sign` for one cycle, then go to WAIT.
- WAIT: `pass_p` → IDLE. `lose_p` → OVER. If both arrive in the same cycle, `lose_p` wins.
- OVER: sticky. Every input is ignored; only `rst_n` leaves OVER.
- Ignored inputs: `start_p` outside IDLE, `stop_p` outside SPIN, `pass_p`/`lose_p` outside WAIT.
- Boundary cases:
  - `stop_p` in the same cycle as a step tick: the stop wins and the reel freezes at its pre-step value. Other spinning reels still step.
  - `stop_p` and auto-stop in the same cycle: exactly one reel stops.
  - `refresh` saturates at 3 and holds that value until the next `turn_p`.
  - Numbers never leave 0–9; the wrap is modular, e.g. 8+3 → 1 and 9+7 → 6.
- Reset asserted mid-turn: immediately returns every register to its reset value. No pulse is emitted.

## Timing
- `start_p` sampled at edge n → `turn_p` and `busy` high during cycle n+1 through n+2. First reel step at edge n+SPIN_DIV+1.
- Stop sampled at edge m → that reel's value is frozen from edge m, and `ref_sign`/`refresh` update at edge m+1.
- Third stop sampled at edge m → `score_sign` high during cycle m+2 only.
- Verdict sampled at edge v → state IDLE/OVER and `busy` low from edge v+1.
- Earliest accepted next `start_p` is the cycle after `busy` falls.
- Auto-stop fires AUTO_STOP cycles after the turn start or after the previous stop.

## Test plan
- Reset with SPIN_DIV=4 → numbers 0/0/0, `refresh` 0, all pulses 0, `busy` 0. Release, pulse `start_p` → `turn_p` exactly one cycle later. After 3 step ticks the reels read 3/9/1.
- Three `stop_p` pulses 10 cycles apart → `ref_sign` three times with `refresh` 1, 2, 3; frozen reels never change again; `score_sign` once, 1 cycle after the third `ref_sign`.
- No `stop_p`, AUTO_STOP=64 → stops at cycles 64, 128 and 192 after the turn start, then `score_sign`.
- `stop_p` coincident with a step tick while reel 2 = 8 → reel 2 freezes at 8, not 1.
- In WAIT, assert `pass_p` and `lose_p` together → OVER; later `start_p` gives no `turn_p`; `rst_n` pulse → IDLE with reset values.
- Assert `rst_n` low mid-SPIN with `refresh`=1 → all outputs at reset values asynchronously; `start_p`, `stop_p` and `pass_p` are ignored in the wrong states.
